cfi_log_queue: RTL and testbench

Log FIFO between the commit-side CFI log generator and the CFI backend.
- Buffers committed control-flow log records (cfi_log_t) pushed by the commit stage.
- Presents the head record to the backend in first-word-fall-through (FWFT) fashion and pops it on the backend's request.
- Gives backpressure to commit (full/almost-full) and records overflow as a sticky error.

---
 rtl/cfi_log_queue.sv | 148 ++++++++++++++
 tb/tb_cfi_log_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cfi_log_queue.sv
// -----------------------------------------------------------------------------
// cfi_log_queue
//
// Log FIFO between the commit-side CFI log generator and the CFI backend.
// Commit pushes control-flow log records; the backend sees the head record
// first-word-fall-through and removes it with a pop strobe. Backpressure is
// given through full/almost-full, and a push that arrives while the queue is
// full (with no concurrent pop) is dropped and recorded in a sticky overflow
// flag that only reset clears.
//
// Optional feature macro: CFI_LOG_QUEUE_FLUSH_EN
//   Defined   : adds input flush_i, which empties the queue (pointers and count
//               to zero) with priority over push/pop; overflow is unchanged.
//   Undefined : no flush_i port; the queue empties only through pops or reset.
//
// Ports:
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   push_i         commit-side write strobe
//   log_i          record to enqueue (sampled when push_i=1)
//   full_o         queue holds DEPTH entries
//   almost_full_o  occupancy >= AFULL_THRESH
//   log_o          head record, valid when empty_o=0
//   empty_o        queue holds no entries
//   pop_i          backend pop strobe
//   usage_o        current occupancy, 0..DEPTH
//   overflow_o     sticky: a push was dropped because the queue was full
//   flush_i        (CFI_LOG_QUEUE_FLUSH_EN only) discard all entries
// -----------------------------------------------------------------------------
module cfi_log_queue #(
   parameter int  DEPTH        = 8,
   // Width of cfi_pkg::cfi_log_t (256 bits in the current record definition).
   parameter int  LOG_WIDTH    = 256,
   parameter int  AFULL_THRESH = DEPTH - 1,
   localparam int PTR_W        = $clog2(DEPTH),
   localparam int CNT_W        = $clog2(DEPTH) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
`ifdef CFI_LOG_QUEUE_FLUSH_EN
   input  logic                 flush_i,
`endif
   input  logic                 push_i,
   input  logic [LOG_WIDTH-1:0] log_i,
   output logic                 full_o,
   output logic                 almost_full_o,
   output logic [LOG_WIDTH-1:0] log_o,
   output logic                 empty_o,
   input  logic                 pop_i,
   output logic [CNT_W-1:0]     usage_o,
   output logic                 overflow_o
);

   logic [LOG_WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             overflow_q, overflow_d;

   logic full_s;
   logic empty_s;
   logic flush_s;
   logic pop_eff_s;
   logic push_acc_s;
   logic push_drop_s;

`ifdef CFI_LOG_QUEUE_FLUSH_EN
   assign flush_s = flush_i;
`else
   assign flush_s = 1'b0;
`endif

   // Status decoded purely from registered occupancy.
   assign full_s  = (count_q == CNT_W'(DEPTH));
   assign empty_s = (count_q == {CNT_W{1'b0}});

   // Accept/pop qualification; a pop frees a slot for a same-cycle push when
   // full, while a pop on an empty queue is simply ignored. Flush overrides
   // both, and a push lost to a flush is not an overflow.
   assign pop_eff_s   = pop_i & ~empty_s & ~flush_s;
   assign push_acc_s  = push_i & (~full_s | (pop_i & ~empty_s)) & ~flush_s;
   assign push_drop_s = push_i & ~(~full_s | (pop_i & ~empty_s)) & ~flush_s;

   // Next-state computation for pointers, occupancy and sticky overflow.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (flush_s) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (push_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_eff_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_acc_s, pop_eff_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if (push_drop_s) begin
            overflow_d = 1'b1;
         end else begin
            overflow_d = overflow_q;
         end
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q   <= {PTR_W{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
         count_q    <= {CNT_W{1'b0}};
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Record storage; never cleared, contents only meaningful below count_q.
   always_ff @(posedge clk_i) begin
      if (rst_ni && push_acc_s) begin
         mem_q[wr_ptr_q] <= log_i;
      end
   end

   assign log_o         = mem_q[rd_ptr_q];
   assign empty_o       = empty_s;
   assign full_o        = full_s;
   assign usage_o       = count_q;
   assign almost_full_o = (count_q >= CNT_W'(AFULL_THRESH));
   assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_cfi_log_queue.sv
// -----------------------------------------------------------------------------
// tb_cfi_log_queue
//
// Self-checking bench for cfi_log_queue (DEPTH=8, LOG_WIDTH=256). A reference
// model tracks occupancy and the sticky overflow flag; accepted records are
// pushed to a scoreboard queue and popped/compared when the DUT pops them.
// The flush scenario is included when CFI_LOG_QUEUE_FLUSH_EN is defined.
// -----------------------------------------------------------------------------
module tb_cfi_log_queue;

   localparam int DEPTH = 8;
   localparam int LW    = 256;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk_i;
   logic          rst_ni;
   logic          push_i;
   logic [LW-1:0] log_i;
   logic          full_o;
   logic          almost_full_o;
   logic [LW-1:0] log_o;
   logic          empty_o;
   logic          pop_i;
   logic [CW-1:0] usage_o;
   logic          overflow_o;
`ifdef CFI_LOG_QUEUE_FLUSH_EN
   logic          flush_i;
`endif

   cfi_log_queue #(
      .DEPTH        (DEPTH),
      .LOG_WIDTH    (LW),
      .AFULL_THRESH (DEPTH - 1)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
`ifdef CFI_LOG_QUEUE_FLUSH_EN
      .flush_i       (flush_i),
`endif
      .push_i        (push_i),
      .log_i         (log_i),
      .full_o        (full_o),
      .almost_full_o (almost_full_o),
      .log_o         (log_o),
      .empty_o       (empty_o),
      .pop_i         (pop_i),
      .usage_o       (usage_o),
      .overflow_o    (overflow_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int unsigned   n_checks = 0;
   int unsigned   n_fail   = 0;

   logic [LW-1:0] sb_q[$];
   int            m_count  = 0;
   logic          m_ovf    = 1'b0;

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, ":usage"},  LW'(usage_o),       LW'(m_count));
      check({tag, ":empty"},  LW'(empty_o),       LW'(m_count == 0));
      check({tag, ":full"},   LW'(full_o),        LW'(m_count == DEPTH));
      check({tag, ":afull"},  LW'(almost_full_o), LW'(m_count >= DEPTH - 1));
      check({tag, ":ovf"},    LW'(overflow_o),    LW'(m_ovf));
      if (m_count > 0) begin
         check({tag, ":head"}, log_o, sb_q[0]);
      end
   endtask

   // One clock cycle of stimulus; model updated from pre-edge state.
   task automatic step(input string tag, input logic push, input logic [LW-1:0] data, input logic pop);
      logic pop_eff;
      logic push_acc;
      logic [LW-1:0] exp;
      push_i   = push;
      log_i    = data;
      pop_i    = pop;
      pop_eff  = pop && (m_count != 0);
      push_acc = push && ((m_count != DEPTH) || pop_eff);
      if (pop_eff) begin
         exp = sb_q.pop_front();
         check({tag, ":pop_data"}, log_o, exp);
      end
      if (push_acc) sb_q.push_back(data);
      if (push && !push_acc) m_ovf = 1'b1;
      if (push_acc && !pop_eff) m_count++;
      if (pop_eff && !push_acc) m_count--;
      @(posedge clk_i);
      #1;
      push_i = 1'b0;
      pop_i  = 1'b0;
      check_status(tag);
   endtask

   task automatic do_reset(input string tag);
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      sb_q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      check_status(tag);
   endtask

   initial begin
      rst_ni = 1'b0;
      push_i = 1'b0;
      pop_i  = 1'b0;
      log_i  = '0;
`ifdef CFI_LOG_QUEUE_FLUSH_EN
      flush_i = 1'b0;
`endif
      @(posedge clk_i);
      #1;
      do_reset("reset");

      // 1: single record latency and pop
      step("t1_push", 1'b1, LW'(8'hA5), 1'b0);
      check("t1_log", log_o, LW'(8'hA5));
      step("t1_pop", 1'b0, '0, 1'b1);

      // 2: fill, overflow on 9th push, drain in order
      for (int i = 0; i < DEPTH; i++) step("t2_fill", 1'b1, LW'(i), 1'b0);
      step("t2_over", 1'b1, LW'(99), 1'b0);
      for (int i = 0; i < DEPTH; i++) step("t2_drain", 1'b0, '0, 1'b1);

      // 3: full queue with simultaneous push and pop
      do_reset("t3_reset");
      for (int i = 0; i < DEPTH; i++) step("t3_fill", 1'b1, LW'(i), 1'b0);
      step("t3_pp", 1'b1, LW'(8), 1'b1);
      check("t3_head", log_o, LW'(1));
      for (int i = 0; i < DEPTH; i++) step("t3_drain", 1'b0, '0, 1'b1);

      // 4: interleaved push/pop across pointer wrap
      for (int i = 0; i < 20; i++) step("t4_mix", 1'b1, LW'(100 + i), (i % 2) == 1);
      while (m_count > 0) step("t4_drain", 1'b0, '0, 1'b1);
      for (int i = 0; i < 60; i++) begin
         step("t4_rand", 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
      end
      while (m_count > 0) step("t4_rdrain", 1'b0, '0, 1'b1);

      // 5: pop on empty, then push+pop on empty
      do_reset("t5_reset");
      step("t5_pop_empty", 1'b0, '0, 1'b1);
      step("t5_pp_empty", 1'b1, LW'(16'hBEEF), 1'b1);
      check("t5_log", log_o, LW'(16'hBEEF));
      step("t5_pop", 1'b0, '0, 1'b1);

`ifdef CFI_LOG_QUEUE_FLUSH_EN
      // 6a: flush with concurrent push; overflow kept
      for (int i = 0; i < DEPTH; i++) step("t6_fill", 1'b1, LW'(i), 1'b0);
      step("t6_over", 1'b1, LW'(77), 1'b0);
      for (int i = 0; i < 3; i++) step("t6_pop", 1'b0, '0, 1'b1);
      flush_i = 1'b1;
      push_i  = 1'b1;
      log_i   = LW'(55);
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      push_i  = 1'b0;
      sb_q.delete();
      m_count = 0;
      check_status("t6_flush");
      step("t6_after", 1'b1, LW'(66), 1'b0);
      step("t6_after_pop", 1'b0, '0, 1'b1);
`endif

      // 6b: reset mid-operation with 3 entries after an overflow
      for (int i = 0; i < DEPTH; i++) step("t6b_fill", 1'b1, LW'(i), 1'b0);
      step("t6b_over", 1'b1, LW'(1), 1'b0);
      for (int i = 0; i < 5; i++) step("t6b_pop", 1'b0, '0, 1'b1);
      check("t6b_usage3", LW'(usage_o), LW'(3));
      do_reset("t6b_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
